// File: rtl/audio_sfx_scheduler.sv
// Sample pacer for the codec DAC FIFO: mixes crash and score effect
// tones over the music square wave with crash > score > music priority.
module audio_sfx_scheduler #(
  parameter logic [23:0] AMPL       = 24'h100000,
  parameter logic [15:0] CRASH_HALF = 16'd120,
  parameter logic [15:0] SCORE_HALF = 16'd30,
  parameter logic [15:0] CRASH_LEN  = 16'd24000,
  parameter logic [15:0] SCORE_LEN  = 16'd6000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        music_level,
  input  logic        music_en,
  input  logic        crash_evt,
  input  logic        score_evt,
  input  logic        write_ready,
  output logic        write,
  output logic [23:0] writedata_left,
  output logic [23:0] writedata_right,
  output logic [1:0]  active_src,
  output logic        busy
);

  typedef enum logic {IDLE, WRITE} state_t;

  localparam logic [1:0] SRC_MUSIC = 2'd0;
  localparam logic [1:0] SRC_SCORE = 2'd1;
  localparam logic [1:0] SRC_CRASH = 2'd2;
  localparam logic [23:0] MUS = AMPL >> 1;

  state_t      state, state_nx;
  logic        load;
  logic [1:0]  src_nx;
  logic [23:0] data_nx, data_q;

  logic        crash_act, crash_pol;
  logic [15:0] crash_ph, crash_cnt;
  logic        score_act, score_pol, score_pend;
  logic [15:0] score_ph, score_cnt;

  logic crash_adv, score_adv;
  logic score_start, score_conv;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    unique case (state)
      IDLE: if (write_ready) begin
        state_nx = WRITE;
        load     = 1'b1;
      end
      WRITE: state_nx = IDLE;
    endcase
  end

  // A pending score is about to restart, so its first sample is positive
  always_comb begin
    src_nx  = SRC_MUSIC;
    data_nx = 24'd0;
    if (crash_act) begin
      src_nx  = SRC_CRASH;
      data_nx = crash_pol ? -AMPL : AMPL;
    end else if (score_act || score_pend) begin
      src_nx  = SRC_SCORE;
      data_nx = (score_pol && !score_pend) ? -AMPL : AMPL;
    end else if (music_en) begin
      data_nx = music_level ? MUS : -MUS;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q     <= 24'd0;
      active_src <= SRC_MUSIC;
    end else if (load) begin
      data_q     <= data_nx;
      active_src <= src_nx;
    end
  end

  assign write           = (state == WRITE);
  assign writedata_left  = data_q;
  assign writedata_right = data_q;
  assign busy            = crash_act | score_act | score_pend;

  assign crash_adv = write & (active_src == SRC_CRASH) & crash_act;
  assign score_adv = write & (active_src == SRC_SCORE) & score_act;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crash_act <= 1'b0;
      crash_pol <= 1'b0;
      crash_ph  <= 16'd0;
      crash_cnt <= 16'd0;
    end else if (crash_evt) begin
      crash_act <= 1'b1;
      crash_pol <= 1'b0;
      crash_ph  <= 16'd0;
      crash_cnt <= 16'd0;
    end else if (crash_adv) begin
      if (crash_cnt == CRASH_LEN - 16'd1) begin
        crash_act <= 1'b0;
        crash_pol <= 1'b0;
        crash_ph  <= 16'd0;
        crash_cnt <= 16'd0;
      end else begin
        crash_cnt <= crash_cnt + 16'd1;
        if (crash_ph == CRASH_HALF - 16'd1) begin
          crash_ph  <= 16'd0;
          crash_pol <= ~crash_pol;
        end else begin
          crash_ph <= crash_ph + 16'd1;
        end
      end
    end
  end

  assign score_start = score_evt & ~crash_act & ~crash_evt;
  assign score_conv  = score_pend & ~crash_act & ~crash_evt;

  // An interrupted score keeps its counters; only a new request resets them
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score_act  <= 1'b0;
      score_pol  <= 1'b0;
      score_pend <= 1'b0;
      score_ph   <= 16'd0;
      score_cnt  <= 16'd0;
    end else if (score_start || score_conv) begin
      score_act  <= 1'b1;
      score_pol  <= 1'b0;
      score_pend <= 1'b0;
      score_ph   <= 16'd0;
      score_cnt  <= 16'd0;
    end else begin
      if (score_evt) score_pend <= 1'b1;
      if (score_adv) begin
        if (score_cnt == SCORE_LEN - 16'd1) begin
          score_act <= 1'b0;
          score_pol <= 1'b0;
          score_ph  <= 16'd0;
          score_cnt <= 16'd0;
        end else begin
          score_cnt <= score_cnt + 16'd1;
          if (score_ph == SCORE_HALF - 16'd1) begin
            score_ph  <= 16'd0;
            score_pol <= ~score_pol;
          end else begin
            score_ph <= score_ph + 16'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_sfx_scheduler.sv
// Directed + randomized bench for audio_sfx_scheduler; expected samples
// come from square-wave arithmetic on the sample index.
module tb_audio_sfx_scheduler;

  localparam logic [23:0] POS  = 24'h100000;
  localparam logic [23:0] NEG  = 24'hF00000;
  localparam logic [23:0] MPOS = 24'h080000;
  localparam logic [23:0] MNEG = 24'hF80000;

  logic clk = 1'b0;
  logic reset, music_level, music_en;
  logic crash_evt, score_evt, write_ready;
  logic write, busy, write2, busy2;
  logic [23:0] wd_l, wd_r, wd2_l, wd2_r;
  logic [1:0] src, src2;

  int checks = 0;
  int failures = 0;
  int cyc_cnt = 0;
  bit busy_watch = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  audio_sfx_scheduler #(
    .CRASH_HALF(16'd4), .SCORE_HALF(16'd2),
    .CRASH_LEN(16'd6), .SCORE_LEN(16'd8)
  ) u_dut (
    .clk(clk), .reset(reset),
    .music_level(music_level), .music_en(music_en),
    .crash_evt(crash_evt), .score_evt(score_evt),
    .write_ready(write_ready), .write(write),
    .writedata_left(wd_l), .writedata_right(wd_r),
    .active_src(src), .busy(busy)
  );

  audio_sfx_scheduler #(
    .CRASH_HALF(16'd4), .SCORE_HALF(16'd2),
    .CRASH_LEN(16'd16), .SCORE_LEN(16'd8)
  ) u_long (
    .clk(clk), .reset(reset),
    .music_level(music_level), .music_en(music_en),
    .crash_evt(crash_evt), .score_evt(score_evt),
    .write_ready(write_ready), .write(write2),
    .writedata_left(wd2_l), .writedata_right(wd2_r),
    .active_src(src2), .busy(busy2)
  );

  function automatic logic [23:0] tone(input int k, input int half);
    return (((k / half) % 2) == 1) ? NEG : POS;
  endfunction

  function automatic logic [23:0] music(input logic lvl, input logic en);
    if (!en) return 24'd0;
    return lvl ? MPOS : MNEG;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic next_write(input bit two, output logic [23:0] dl,
                            output logic [23:0] dr, output logic [1:0] s);
    bit got = 0;
    dl = 'x; dr = 'x; s = 'x;
    for (int i = 0; i < 20 && !got; i++) begin
      cyc();
      if (busy_watch) chk("busy_hold", two ? busy2 : busy, 1);
      if (two ? write2 : write) begin
        got = 1;
        dl = two ? wd2_l : wd_l;
        dr = two ? wd2_r : wd_r;
        s  = two ? src2 : src;
      end
    end
    if (!got) chk("write_timeout", {31'd0, got}, 1);
  endtask

  task automatic tone_write(input string tag, input bit two, input bit skip,
                            input logic [1:0] s_exp, input int half,
                            input int k);
    logic [23:0] dl, dr;
    logic [1:0] s;
    next_write(two, dl, dr, s);
    if (skip)
      for (int i = 0; i < 4 && s == 2'd0; i++) next_write(two, dl, dr, s);
    chk($sformatf("%s_src_k%0d", tag, k), s, s_exp);
    chk($sformatf("%s_l_k%0d", tag, k), dl, tone(k, half));
    chk($sformatf("%s_r_k%0d", tag, k), dr, tone(k, half));
  endtask

  task automatic music_write(input string tag, input logic [23:0] exp);
    logic [23:0] dl, dr;
    logic [1:0] s;
    next_write(0, dl, dr, s);
    chk({tag, "_src"}, s, 0);
    chk({tag, "_data"}, dl, exp);
  endtask

  initial begin
    logic [23:0] dl, dr;
    logic [1:0] s;
    int last;
    bit exp_w, nx_w;
    logic r_lvl, r_en, r_rdy;

    reset = 1; music_level = 0; music_en = 0;
    crash_evt = 0; score_evt = 0; write_ready = 0;
    #2;
    chk("reset_write", write, 0);
    chk("reset_data", wd_l, 0);
    chk("reset_src", src, 0);
    chk("reset_busy", busy, 0);
    repeat (3) cyc();
    @(negedge clk) reset = 0;
    #1 chk("post_reset_write", write, 0);

    music_en = 1; music_level = 1; write_ready = 1;
    last = 0;
    for (int i = 0; i < 6; i++) begin
      next_write(0, dl, dr, s);
      chk("idle_data", dl, MPOS);
      chk("idle_data_r", dr, MPOS);
      chk("idle_src", s, 0);
      if (i > 0) chk("idle_gap", cyc_cnt - last, 2);
      last = cyc_cnt;
    end

    write_ready = 0;
    cyc(); cyc();
    exp_w = 0;
    repeat (200) begin
      r_lvl = 1'($urandom_range(0, 1));
      r_en  = 1'($urandom_range(0, 1));
      r_rdy = ($urandom_range(0, 3) != 0);
      music_level = r_lvl; music_en = r_en; write_ready = r_rdy;
      cyc();
      nx_w = !exp_w && r_rdy;
      chk("rand_write", write, nx_w);
      if (nx_w) chk("rand_data", wd_l, music(r_lvl, r_en));
      exp_w = nx_w;
    end

    music_en = 1; music_level = 0; write_ready = 1;
    score_evt = 1; cyc(); score_evt = 0;
    for (int k = 0; k < 8; k++) tone_write("score", 0, k == 0, 1, 2, k);
    cyc();
    chk("score_busy_fall", busy, 0);
    music_write("score_after", MNEG);

    score_evt = 1; cyc(); score_evt = 0;
    for (int k = 0; k < 3; k++) tone_write("pre_s", 0, k == 0, 1, 2, k);
    crash_evt = 1; cyc(); crash_evt = 0;
    for (int k = 0; k < 6; k++) tone_write("pre_c", 0, 0, 2, 4, k);
    for (int k = 3; k < 8; k++) tone_write("pre_r", 0, 0, 1, 2, k);
    music_write("pre_after", MNEG);

    crash_evt = 1; score_evt = 1; cyc();
    crash_evt = 0; score_evt = 0;
    busy_watch = 1;
    for (int k = 0; k < 6; k++) tone_write("sim_c", 0, k == 0, 2, 4, k);
    for (int k = 0; k < 8; k++) tone_write("sim_s", 0, 0, 1, 2, k);
    busy_watch = 0;
    cyc();
    chk("sim_busy_fall", busy, 0);
    music_write("sim_after", MNEG);

    score_evt = 1; cyc(); score_evt = 0;
    for (int k = 0; k < 3; k++) tone_write("bp_a", 0, k == 0, 1, 2, k);
    write_ready = 0;
    repeat (50) begin
      cyc();
      chk("bp_no_write", write, 0);
      chk("bp_busy", busy, 1);
    end
    write_ready = 1;
    for (int k = 3; k < 8; k++) tone_write("bp_b", 0, 0, 1, 2, k);
    music_write("bp_after", MNEG);

    music_en = 0;
    reset = 1; cyc();
    @(negedge clk) reset = 0;
    crash_evt = 1; cyc(); crash_evt = 0;
    for (int k = 0; k < 10; k++) begin
      tone_write("long_c", 1, k == 0, 2, 4, k);
      if (k == 4) begin
        score_evt = 1; cyc(); score_evt = 0;
      end
    end
    #2 reset = 1;
    #1;
    chk("rst_mid_write", write2, 0);
    chk("rst_mid_l", wd2_l, 0);
    chk("rst_mid_r", wd2_r, 0);
    chk("rst_mid_src", src2, 0);
    chk("rst_mid_busy", busy2, 0);
    cyc();
    @(negedge clk) reset = 0;
    #1 chk("rst_rel_write", write2, 0);
    next_write(1, dl, dr, s);
    chk("rst_after_src", s, 0);
    chk("rst_after_data", dl, 0);
    chk("rst_after_busy", busy2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
